bus_source_arbiter: RTL
=======================

# bus_source_arbiter

Registered round-robin arbiter that turns the 32 per-source bus-drive request lines from the control unit into the 5-bit select (Sel4..Sel0) for the 32-to-1 datapath bus multiplexer. It sits directly upstream of the bus multiplexer. It guarantees exactly one bus source per cycle, holds the select stable while a transfer is locked, and flags control-unit errors where two sources request the bus in the same cycle.

## Interface
- No parameters. Source count is fixed at 32 and select width is fixed at 5.
- clock  in  1  system clock; all state changes on its rising edge
- clear  in  1  synchronous, active-high reset
- req  in  32  per-source bus request; bit i = source i wants to drive the bus (i matches bus multiplexer input In<i>)
- hold  in  1  lock the current grant while its request stays asserted
- Sel0, Sel1, Sel2, Sel3, Sel4  out  1 each  registered select, Sel4 = MSB; drives the bus multiplexer select inputs
- grant  out  32  registered one-hot grant; all zeros when idle
- busValid  out  1  registered; 1 when grant/Sel name a live source
- conflict  out  1  registered; 1 if more than one req bit was set in the previous cycle
- conflictCount  out  8  saturating count of cycles with conflict

## Operation
- Internal state:
  - ptr[4:0]: round-robin start index.
  - cur[4:0]: current select, exported as Sel4..Sel0.
  - grant, busValid, conflict, conflictCount.
- Arbitration, evaluated each cycle when not locked:
  - Scan req from index ptr upward, wrapping 31 -> 0.
  - The first set bit k wins.
  - Next state: grant = 1<<k, cur = k, busValid = 1, ptr = (k+1) mod 32.
- Lock:
  - The grant is locked when hold=1, busValid=1 and req[cur]=1.
  - While locked, grant, cur and ptr are unchanged and other requests are ignored.
  - If req[cur] drops while hold=1, the lock releases and normal arbitration applies in that same cycle.
- Idle (req == 0, not locked):
  - grant = 0 and busValid = 0.
  - cur keeps its last value so the bus multiplexer select does not toggle; ptr is unchanged.
- Conflict detection:
  - conflict_next = 1 when popcount(req) >= 2, regardless of lock.
  - conflictCount increments on each such cycle and saturates at 255.
- Reset: clear=1 at a rising edge sets grant=0, Sel4..Sel0=0, busValid=0, conflict=0, conflictCount=0, ptr=0. Reset overrides hold and req, including mid-lock.
- Two-state view per cycle: IDLE (busValid=0) and GRANTED (busValid=1, with a locked sub-condition).
  - IDLE -> GRANTED: any req.
  - GRANTED -> GRANTED: re-arbitrate, or locked.
  - GRANTED -> IDLE: req == 0 and not locked.

## Timing
- Latency is 1 cycle: req sampled at edge n appears on grant/Sel/busValid after edge n.
- All outputs are registers. There is no combinational path from req or hold to any output.
- Sel4..Sel0 always equals the binary index of the set grant bit whenever busValid=1.
- conflict and conflictCount update on the same edge as the grant they relate to.
- Wrap-around: with ptr=31, req[31] wins before req[0]. After granting 31, ptr=0.
- With a single steady requester k, the grant stays on k every cycle and ptr stays k+1.
- Lock and new requests in the same cycle: the lock wins, and the new requests are served after release in round-robin order.

## Test plan
- **Reset:** assert clear for 2 cycles with req=32'hFFFFFFFF, hold=1. Required: grant=0, Sel=0, busValid=0, conflict=0, conflictCount=0. On the first edge after clear drops, grant=32'h00000001 and Sel=0.
- **Single source:** req=32'h00080000 (source 19) for 3 cycles. Required: one cycle later Sel4..Sel0=5'b10011, grant=32'h00080000, busValid=1, conflict=0.
- **Round-robin wrap:** after a grant of 31 (ptr=0), hold req=32'h80000003 for 4 cycles. Required: grants in order 0, 1, 31, 0. conflict=1 each cycle; conflictCount increases by 4.
- **Lock:**
  - Grant source 5 with hold=1, then raise req[6].
  - Required: grant stays 5 for as long as req[5]=1.
  - Drop req[5] while keeping req[6]: the next edge grants 6.
- **Idle holds select:** after a grant of 12, set req=0. Required: busValid=0, grant=0, Sel stays 5'b01100.
- **Saturation and reset mid-lock:**
  - Drive 300 conflicting cycles. Required: conflictCount=255.
  - Then assert clear while locked. Required: all outputs reset on that edge.

Source files
------------

// File: rtl/bus_source_arbiter.sv
// -----------------------------------------------------------------------------
// bus_source_arbiter
//
// Registered round-robin arbiter for the 32-to-1 datapath bus multiplexer.
// Each cycle it picks exactly one requesting source, starting the search at a
// rotating pointer. The chosen index is presented as a 5-bit select and as a
// one-hot grant. A transfer can be locked with hold. Cycles in which the
// control unit asserted more than one request are flagged and counted.
//
// Ports
//   clock          in   1   system clock, rising edge
//   clear          in   1   synchronous active-high reset
//   req            in  32   per-source bus request, bit i = mux input In<i>
//   hold           in   1   keep the current grant while its request stays up
//   Sel0..Sel4     out  1   registered mux select, Sel4 = MSB
//   grant          out 32   registered one-hot grant, zero when idle
//   busValid       out  1   registered, grant/Sel name a live source
//   conflict       out  1   registered, >1 request bit seen last cycle
//   conflictCount  out  8   saturating count of conflict cycles
//
// State table
//   ST_IDLE    | no source drives the bus, select parked on last value
//   ST_GRANTED | grant/Sel valid; may be locked by hold
// -----------------------------------------------------------------------------
module bus_source_arbiter (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] req,
  input  logic        hold,
  output logic        Sel0,
  output logic        Sel1,
  output logic        Sel2,
  output logic        Sel3,
  output logic        Sel4,
  output logic [31:0] grant,
  output logic        busValid,
  output logic        conflict,
  output logic [7:0]  conflictCount
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  cur_q, cur_d;
  logic [31:0] grant_q, grant_d;
  logic        conflict_q, conflict_d;
  logic [7:0]  conflict_count_q, conflict_count_d;

  logic        win_found;
  logic [4:0]  win_idx;
  logic [4:0]  scan_idx;
  logic        locked;
  logic        multi_req;

  // Rotating priority scan: first set request at or above ptr, wrapping 31->0.
  // The 5-bit add wraps naturally.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < 32; i++) begin
      scan_idx = ptr_q + 5'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_req = |(req & (req - 32'd1));

  assign locked = hold && (state_q == ST_GRANTED) && req[cur_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    grant_d = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANTED;
          grant_d = 32'd1 << win_idx;
          cur_d   = win_idx;
          ptr_d   = win_idx + 5'd1;
        end
      end
      ST_GRANTED: begin
        if (locked) begin
          // Lock wins over every other request; nothing moves.
          state_d = ST_GRANTED;
        end else if (win_found) begin
          state_d = ST_GRANTED;
          grant_d = 32'd1 << win_idx;
          cur_d   = win_idx;
          ptr_d   = win_idx + 5'd1;
        end else begin
          // cur stays put so the mux select does not toggle while idle.
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    conflict_d       = multi_req;
    conflict_count_d = conflict_count_q;
    if (multi_req && (conflict_count_q != 8'hFF)) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q          <= ST_IDLE;
      ptr_q            <= '0;
      cur_q            <= '0;
      grant_q          <= '0;
      conflict_q       <= 1'b0;
      conflict_count_q <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      cur_q            <= cur_d;
      grant_q          <= grant_d;
      conflict_q       <= conflict_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign Sel0          = cur_q[0];
  assign Sel1          = cur_q[1];
  assign Sel2          = cur_q[2];
  assign Sel3          = cur_q[3];
  assign Sel4          = cur_q[4];
  assign grant         = grant_q;
  assign busValid      = (state_q == ST_GRANTED);
  assign conflict      = conflict_q;
  assign conflictCount = conflict_count_q;

endmodule
